// File: rtl/boot_pkg.sv
// Shared types and constants for the warm-boot selector.
// State encodings, image slots and the cold-boot image choice.
package boot_pkg;

  typedef enum logic [1:0] {
    ST_STARTUP = 2'd0,
    ST_IDLE    = 2'd1,
    ST_SETUP   = 2'd2,
    ST_BOOT    = 2'd3
  } state_t;

  localparam logic [1:0] IMG_SELF  = 2'd0;
  localparam logic [1:0] IMG_DFU   = 2'd1;
  localparam logic [1:0] IMG_APP   = 2'd2;
  localparam logic [1:0] IMG_SPARE = 2'd3;

  // A held button at power-up selects DFU, otherwise the application.
  function automatic logic [1:0] cold_image(input logic pressed);
    return pressed ? IMG_DFU : IMG_APP;
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchronizer and debounce counter for the active-low button.
// button_pressed is 1 while the filtered button level is low.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 1200
) (
  input  logic pin_clk,
  input  logic reset,
  input  logic pin_button,
  output logic button_pressed
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic [CW-1:0] cnt;

  // Bring the asynchronous pin into the clock domain; idle level is released.
  always_ff @(posedge pin_clk) begin
    if (reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= pin_button;
      sync2 <= sync1;
    end
  end

  // Flip the filtered level only after a run of differing samples.
  always_ff @(posedge pin_clk) begin
    if (reset) begin
      level <= 1'b1;
      cnt   <= '0;
    end else if (sync2 == level) begin
      cnt   <= '0;
    end else if (cnt >= CNT_LAST) begin
      level <= sync2;
      cnt   <= '0;
    end else begin
      cnt   <= cnt + 1'b1;
    end
  end

  assign button_pressed = ~level;

endmodule

// File: rtl/boot_select.sv
// Warm-boot image selector driving SB_WARMBOOT S1/S0/BOOT.
// Cold-boot choice after startup, software requests and long-press DFU.
module boot_select
  import boot_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES   = 1200,
  parameter int STARTUP_CYCLES    = 255,
  parameter int SETUP_CYCLES      = 4,
  parameter int LONG_PRESS_CYCLES = 12000000,
  parameter int AUTO_BOOT         = 1
) (
  input  logic       pin_clk,
  input  logic       reset,
  input  logic       pin_button,
  input  logic       req_valid,
  input  logic [1:0] req_image,
  output logic       req_ready,
  output logic       button_pressed,
  output logic       warm_s1,
  output logic       warm_s0,
  output logic       warm_boot,
  output logic       busy
);

  localparam int STW = $clog2(STARTUP_CYCLES + 1);
  localparam int SUW = $clog2(SETUP_CYCLES + 1);
  localparam int LPW = $clog2(LONG_PRESS_CYCLES + 1);

  localparam logic [STW-1:0] ST_LOAD = STW'(STARTUP_CYCLES);
  localparam logic [SUW-1:0] SU_LAST = SUW'(SETUP_CYCLES - 1);
  localparam logic [LPW-1:0] LP_MAX  = LPW'(LONG_PRESS_CYCLES);

  state_t         state;
  state_t         state_nx;
  logic [STW-1:0] st_cnt;
  logic [SUW-1:0] su_cnt;
  logic [LPW-1:0] lp_cnt;
  logic [1:0]     img_sel;
  logic           handshake;
  logic           lp_hit;
  logic           enter_setup;

  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .pin_clk       (pin_clk),
    .reset         (reset),
    .pin_button    (pin_button),
    .button_pressed(button_pressed)
  );

  assign handshake   = req_valid && req_ready;
  assign lp_hit      = (lp_cnt == LP_MAX);
  assign enter_setup = (state != ST_SETUP) && (state_nx == ST_SETUP);

  // State register.
  always_ff @(posedge pin_clk) begin
    if (reset) state <= ST_STARTUP;
    else       state <= state_nx;
  end

  // Next state and the image that will be latched on entry to SETUP.
  always_comb begin
    state_nx = state;
    img_sel  = {warm_s1, warm_s0};
    unique case (state)
      ST_STARTUP: begin
        if (st_cnt == '0) begin
          if (AUTO_BOOT != 0) begin
            state_nx = ST_SETUP;
            img_sel  = cold_image(button_pressed);
          end else begin
            state_nx = ST_IDLE;
          end
        end
      end
      ST_IDLE: begin
        if (handshake) begin
          state_nx = ST_SETUP;
          img_sel  = req_image;
        end else if (lp_hit) begin
          state_nx = ST_SETUP;
          img_sel  = IMG_DFU;
        end
      end
      ST_SETUP: begin
        if (su_cnt == SU_LAST) state_nx = ST_BOOT;
      end
      ST_BOOT: begin
        state_nx = ST_BOOT;
      end
      default: state_nx = ST_STARTUP;
    endcase
  end

  // Handshake and status outputs decoded from the current state.
  always_comb begin
    req_ready = (state == ST_IDLE);
    busy      = (state != ST_IDLE);
  end

  // Saturating counters and the registered SB_WARMBOOT drive.
  always_ff @(posedge pin_clk) begin
    if (reset) begin
      st_cnt    <= ST_LOAD;
      su_cnt    <= '0;
      lp_cnt    <= '0;
      warm_s1   <= 1'b0;
      warm_s0   <= 1'b0;
      warm_boot <= 1'b0;
    end else begin
      if (state == ST_STARTUP && st_cnt != '0) st_cnt <= st_cnt - 1'b1;
      if (state == ST_SETUP && su_cnt != SU_LAST) su_cnt <= su_cnt + 1'b1;
      if (state != ST_IDLE || !button_pressed || handshake) begin
        lp_cnt <= '0;
      end else if (!lp_hit) begin
        lp_cnt <= lp_cnt + 1'b1;
      end
      if (enter_setup) begin
        warm_s1 <= img_sel[1];
        warm_s0 <= img_sel[0];
      end
      if (state_nx == ST_BOOT) warm_boot <= 1'b1;
    end
  end

endmodule

// File: tb/tb_boot_select.sv
// Directed bench for boot_select with small timing parameters.
// dut_a auto-boots; dut_b waits in IDLE. Edge eN = Nth edge after reset release.
module tb_boot_select;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       pin_button = 1'b1;
  logic       req_valid = 1'b0;
  logic [1:0] req_image = 2'd0;

  logic a_ready, a_pressed, a_s1, a_s0, a_boot, a_busy;
  logic b_ready, b_pressed, b_s1, b_s0, b_boot, b_busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  boot_select #(
    .DEBOUNCE_CYCLES(4), .STARTUP_CYCLES(16), .SETUP_CYCLES(2),
    .LONG_PRESS_CYCLES(32), .AUTO_BOOT(1)
  ) dut_a (
    .pin_clk(clk), .reset(reset), .pin_button(pin_button),
    .req_valid(req_valid), .req_image(req_image), .req_ready(a_ready),
    .button_pressed(a_pressed), .warm_s1(a_s1), .warm_s0(a_s0),
    .warm_boot(a_boot), .busy(a_busy)
  );

  boot_select #(
    .DEBOUNCE_CYCLES(4), .STARTUP_CYCLES(16), .SETUP_CYCLES(2),
    .LONG_PRESS_CYCLES(32), .AUTO_BOOT(0)
  ) dut_b (
    .pin_clk(clk), .reset(reset), .pin_button(pin_button),
    .req_valid(req_valid), .req_image(req_image), .req_ready(b_ready),
    .button_pressed(b_pressed), .warm_s1(b_s1), .warm_s0(b_s0),
    .warm_boot(b_boot), .busy(b_busy)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] got,
                     input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
  endtask

  initial begin
    // Reset values on both instances.
    pin_button = 1'b1;
    tick(2);
    chk("rst_a", {a_ready, a_pressed, a_s1, a_s0, a_boot, a_busy}, 8'b000001);
    chk("rst_b", {b_ready, b_pressed, b_s1, b_s0, b_boot, b_busy}, 8'b000001);

    // Released button: APP image, warm_boot first high after e19.
    reset = 1'b0;
    tick(16);
    chk("rel_e16", {a_s1, a_s0, a_busy}, 8'b001);
    tick(1);
    chk("rel_e17_s", {a_s1, a_s0, a_boot}, 8'b100);
    tick(1);
    chk("rel_e18_boot", a_boot, 1'b0);
    tick(1);
    chk("rel_e19_boot", a_boot, 1'b1);
    tick(5);
    chk("rel_sticky", {a_s1, a_s0, a_boot, a_busy}, 8'b1011);

    // Pressed from reset: debounce latency, then DFU image.
    pin_button = 1'b0;
    do_reset();
    tick(5);
    chk("prs_db_e5", a_pressed, 1'b0);
    tick(1);
    chk("prs_db_e6", a_pressed, 1'b1);
    tick(11);
    chk("prs_e17_s", {a_s1, a_s0}, 8'b01);
    tick(2);
    chk("prs_e19_boot", a_boot, 1'b1);

    // Bouncing button settling pressed just before the decision.
    pin_button = 1'b1;
    do_reset();
    for (int k = 1; k <= 13; k++) begin
      tick(1);
      pin_button = (k % 4 >= 2) ? 1'b0 : 1'b1;
    end
    pin_button = 1'b0;
    tick(4);
    chk("bnc_e17_db", a_pressed, 1'b0);
    chk("bnc_e17_s", {a_s1, a_s0}, 8'b10);
    tick(2);
    chk("bnc_e19_db", a_pressed, 1'b1);
    chk("bnc_e19_hold", {a_s1, a_s0, a_boot}, 8'b101);

    // IDLE request for image 0.
    pin_button = 1'b1;
    do_reset();
    tick(16);
    chk("req0_e16_rdy", {b_ready, b_busy}, 8'b01);
    tick(1);
    chk("req0_idle", {b_ready, b_busy}, 8'b10);
    req_valid = 1'b1;
    req_image = 2'd0;
    #1;
    chk("req0_rdy_same", b_ready, 1'b1);
    tick(1);
    req_valid = 1'b0;
    chk("req0_setup", {b_ready, b_busy, b_s1, b_s0, b_boot}, 8'b01000);
    tick(1);
    chk("req0_e19_boot", b_boot, 1'b0);
    tick(1);
    chk("req0_e20_boot", b_boot, 1'b1);

    // Long press in IDLE selects DFU.
    pin_button = 1'b0;
    do_reset();
    tick(49);
    chk("lp_e49", {b_busy, b_s0, b_boot}, 8'b000);
    tick(1);
    chk("lp_e50_s", {b_busy, b_s1, b_s0}, 8'b101);
    tick(1);
    chk("lp_e51_boot", b_boot, 1'b0);
    tick(1);
    chk("lp_e52_boot", b_boot, 1'b1);

    // Request coinciding with long-press expiry wins.
    do_reset();
    tick(49);
    req_valid = 1'b1;
    req_image = 2'd2;
    tick(1);
    req_valid = 1'b0;
    chk("race_s", {b_s1, b_s0}, 8'b10);
    tick(2);
    chk("race_boot", {b_s1, b_s0, b_boot}, 8'b101);

    // Reset pulsed during SETUP discards the image and reruns STARTUP.
    pin_button = 1'b1;
    do_reset();
    tick(17);
    chk("mid_setup", a_s1, 1'b1);
    reset = 1'b1;
    tick(1);
    chk("mid_rst", {a_ready, a_s1, a_s0, a_boot, a_busy}, 8'b00001);
    reset = 1'b0;
    tick(18);
    chk("mid_e18_boot", a_boot, 1'b0);
    tick(1);
    chk("mid_e19_boot", {a_s1, a_s0, a_boot}, 8'b101);

    // Request held through STARTUP is accepted once in IDLE; image 3.
    req_valid = 1'b1;
    req_image = 2'd3;
    do_reset();
    tick(16);
    chk("early_rdy", {b_ready, b_busy}, 8'b01);
    tick(1);
    chk("early_idle_rdy", b_ready, 1'b1);
    tick(1);
    req_valid = 1'b0;
    chk("early_acc", {b_ready, b_s1, b_s0}, 8'b011);
    tick(3);
    chk("early_boot", {b_ready, b_s1, b_s0, b_boot}, 8'b0111);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/boot_select.md
Name: boot_select

Overview:
- Upstream driver for the SB_WARMBOOT primitive in the boot header and in application images.
- Debounces the user button and makes the cold-boot image choice after a startup window.
- Accepts software reboot requests, e.g. DFU detach or "run app" from the USB stack.
- Detects a long button press as a request to enter DFU, and sequences S1/S0 setup before pulsing BOOT.

Parameters:
- DEBOUNCE_CYCLES, 1200: consecutive stable synced samples required to change the debounced button state.
- STARTUP_CYCLES, 255: cycles after reset before the cold-boot decision is made.
- SETUP_CYCLES, 4: cycles S1/S0 are held stable before warm_boot asserts.
- LONG_PRESS_CYCLES, 12000000: debounced-pressed duration in IDLE that triggers a reboot to the DFU image.
- AUTO_BOOT, 1: 1 = decide and boot at end of STARTUP; 0 = go to IDLE and wait for a request or long press.

Ports:
- pin_clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- pin_button  in  1  raw button, asynchronous, active-low (0 = pressed).
- req_valid  in  1  software reboot request.
- req_image  in  2  requested image slot, 0..3.
- req_ready  out  1  request accepted when req_valid && req_ready.
- button_pressed  out  1  debounced button, 1 = pressed.
- warm_s1  out  1  to SB_WARMBOOT.S1.
- warm_s0  out  1  to SB_WARMBOOT.S0.
- warm_boot  out  1  to SB_WARMBOOT.BOOT.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset values: req_ready=0, button_pressed=0, warm_s1=0, warm_s0=0, warm_boot=0, busy=1.
- Reset state is STARTUP. The debouncer internal state resets to released; the sync flops reset to 1.
- Button path: 2-flop synchronizer, then debounce counter.
  - The counter clears whenever the synced sample equals the debounced state.
  - When it reaches DEBOUNCE_CYCLES-1 while the sample still differs, the debounced state flips on the next edge and the counter clears.
  - Sample-to-button_pressed latency = 2 + DEBOUNCE_CYCLES cycles.
- Counter widths are $clog2(param+1). All counters saturate; none wrap.
- STARTUP:
  - Counter loads STARTUP_CYCLES at reset and decrements each cycle.
  - At 0 with AUTO_BOOT=1: latch image = button_pressed ? 1 (DFU) : 2 (APP), then go to SETUP.
  - At 0 with AUTO_BOOT=0: go to IDLE.
  - req_ready=0 in this state; a held req_valid waits.
- IDLE:
  - req_ready=1, busy=0.
  - On handshake: latch req_image, go to SETUP.
  - The long-press counter counts while button_pressed=1 and clears when it is 0.
  - When it reaches LONG_PRESS_CYCLES: latch image=1, go to SETUP.
  - Handshake and long-press expiry in the same cycle: the request wins and the long-press counter clears.
- SETUP:
  - warm_s1=image[1] and warm_s0=image[0] are registered from the first SETUP cycle and held constant thereafter.
  - After SETUP_CYCLES cycles, go to BOOT.
  - req_ready=0.
- BOOT:
  - warm_boot=1 and is sticky.
  - S1/S0 are unchanged.
  - Terminal state: only reset exits it, since the FPGA reconfigures.
- Cold-boot latency, with the button stable since before reset: warm_boot rises STARTUP_CYCLES+SETUP_CYCLES+2 cycles after reset deasserts (±1 for the state register, fixed by implementation and documented in the bench).
- Reset asserted in any state, including SETUP or BOOT: all outputs return to reset values on the next edge and the latched image is discarded.
- Button changes during SETUP/BOOT are ignored for image selection.
- Image 0 (self) is a legal request.
- Image 3 is passed through unchanged.

Decomposition:
- Package boot_pkg:
  - state encodings ST_STARTUP, ST_IDLE, ST_SETUP, ST_BOOT.
  - image constants IMG_SELF=2'd0, IMG_DFU=2'd1, IMG_APP=2'd2, IMG_SPARE=2'd3.
- Sub-module button_debounce (param DEBOUNCE_CYCLES):
  - inputs pin_clk, reset, pin_button.
  - output button_pressed.
  - contains the synchronizer and debounce counter.
- The FSM and the startup/setup/long-press counters stay in boot_select.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4, STARTUP_CYCLES=16, SETUP_CYCLES=2, LONG_PRESS_CYCLES=32, AUTO_BOOT=1 unless stated.
- Button released (1) throughout -> warm_s1=1, warm_s0=0 from SETUP entry; warm_boot=1 at the documented cycle (~20 after reset release); warm_boot stays 1.
- Button pressed (0) from reset -> S1/S0=0/1 (DFU), warm_boot=1.
- Button bounces every 2 cycles, then settles pressed 3 cycles before the decision -> debounced still released, image=2.
- AUTO_BOOT=0, IDLE, req_valid=1 with req_image=0 -> req_ready=1 same cycle; S1/S0=0/0; warm_boot 2 cycles later.
- AUTO_BOOT=0, button held pressed -> after 32 pressed cycles, S1/S0=0/1 and warm_boot=1.
- Same setup, request for image 2 in the cycle the long-press counter hits 32 -> S1/S0=1/0.
- Reset pulsed during SETUP -> all outputs 0 next cycle; STARTUP reruns; warm_boot only after a full new sequence.
- req_valid asserted during STARTUP -> req_ready=0 until IDLE, then a single accept.
